// File: rtl/regfile_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [IDXW-1:0] {
    REQ_ALU  = 2'd0,
    REQ_MEM  = 2'd1,
    REQ_LINK = 2'd2
  } req_id_e;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: scans upward from ptr_i, wrapping, first request wins.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N  = NREQ,
  parameter int IW = IDXW
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of writeback requesters onto the single register-file
// write port, with a registered write stage and an in-flight write bitmap.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ  = regfile_arb_pkg::NREQ,
  parameter int WIDTH = regfile_arb_pkg::WIDTH,
  parameter int AW    = regfile_arb_pkg::AW,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [(2**AW)-1:0]    pending,
  output logic [IW-1:0]         grant_idx
);

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             accept;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;

  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [IW-1:0]    grant_idx_q;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (sel_idx)
  );

  // Ready depends only on req_valid and ptr_q, never on the write stage.
  assign req_ready = reset_n ? grant : '0;
  assign accept    = reset_n && (|grant);
  assign sel_addr  = req_addr[int'(sel_idx)*AW +: AW];
  assign sel_data  = req_data[int'(sel_idx)*WIDTH +: WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = IW'(rr_next(int'(sel_idx), NREQ));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_idx_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= accept && (sel_addr != '0);
      if (accept) begin
        wr_addr_q   <= sel_addr;
        wr_data_q   <= sel_data;
        grant_idx_q <= sel_idx;
      end
    end
  end

  // A staged write coinciding with a reset edge must not reach the register file.
  assign wr_en     = wr_en_q && reset_n;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_idx = grant_idx_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        pending[req_addr[i*AW +: AW]] = 1'b1;
      end
    end
    if (wr_en) begin
      pending[wr_addr_q] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario tasks with inline checks, plus a negedge scoreboard that models grants and the write stage.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NR = regfile_arb_pkg::NREQ;
  localparam int DW = regfile_arb_pkg::WIDTH;
  localparam int AWL = regfile_arb_pkg::AW;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_ready;
  logic [NR*AWL-1:0]    req_addr = '0;
  logic [NR*DW-1:0]     req_data = '0;
  logic                 wr_en;
  logic [AWL-1:0]       wr_addr;
  logic [DW-1:0]        wr_data;
  logic [(2**AWL)-1:0]  pending;
  logic [1:0]           grant_idx;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_write_arbiter #(.NREQ(NR), .WIDTH(DW), .AW(AWL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pending   (pending),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic [AWL-1:0] addr;
    logic [DW-1:0]  data;
    logic [1:0]     idx;
  } exp_t;

  exp_t sb_q[$];
  int   ptr_m = 0;

  // Scoreboard: each negedge pops the write expected to be staged now and pushes the next one.
  always @(negedge clk) begin
    exp_t           cur;
    exp_t           nxt;
    logic [NR-1:0]  exp_ready;
    logic [31:0]    exp_pend;
    int             g;
    int             j;
    cur.en = 1'b0; cur.addr = '0; cur.data = '0; cur.idx = '0;
    if (sb_q.size() > 0) cur = sb_q.pop_front();

    n_checks++;
    if (wr_en !== (cur.en && reset_n))
      $display("FAIL sb_wr_en: got %b expected %b", wr_en, cur.en && reset_n);
    else n_pass++;
    if (cur.en && reset_n) begin
      n_checks++;
      if (wr_addr !== cur.addr) $display("FAIL sb_wr_addr: got %0d expected %0d", wr_addr, cur.addr);
      else n_pass++;
      n_checks++;
      if (wr_data !== cur.data) $display("FAIL sb_wr_data: got %h expected %h", wr_data, cur.data);
      else n_pass++;
      n_checks++;
      if (grant_idx !== cur.idx) $display("FAIL sb_grant_idx: got %0d expected %0d", grant_idx, cur.idx);
      else n_pass++;
    end

    g = -1;
    if (reset_n) begin
      for (int k = 0; k < NR; k++) begin
        j = (ptr_m + k) % NR;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    n_checks++;
    if (req_ready !== exp_ready) $display("FAIL sb_ready: got %b expected %b", req_ready, exp_ready);
    else n_pass++;

    exp_pend = '0;
    for (int i = 0; i < NR; i++)
      if (req_valid[i]) exp_pend[req_addr[i*AWL +: AWL]] = 1'b1;
    if (cur.en && reset_n) exp_pend[cur.addr] = 1'b1;
    exp_pend[0] = 1'b0;
    n_checks++;
    if (pending !== exp_pend) $display("FAIL sb_pending: got %h expected %h", pending, exp_pend);
    else n_pass++;

    nxt.en = 1'b0; nxt.addr = '0; nxt.data = '0; nxt.idx = '0;
    if (g >= 0) begin
      nxt.addr = req_addr[g*AWL +: AWL];
      nxt.data = req_data[g*DW +: DW];
      nxt.idx  = 2'(g);
      nxt.en   = (nxt.addr != '0);
    end
    sb_q.push_back(nxt);

    if (!reset_n) ptr_m = 0;
    else if (g >= 0) ptr_m = (g + 1) % NR;
  end

  task automatic set_req(input int i, input logic [AWL-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AWL +: AWL] = a;
    req_data[i*DW +: DW]   = d;
    req_valid[i]           = 1'b1;
  endtask

  // Withdraws each requester only once it has been accepted; bounded.
  task automatic drain();
    logic [NR-1:0] r;
    for (int c = 0; c < 20 && req_valid != '0; c++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~r;
    end
    n_checks++;
    if (req_valid != '0) $display("FAIL drain_timeout: valid still %b expected 000", req_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    set_req(0, 5'd1, 32'hA0); set_req(1, 5'd2, 32'hA1); set_req(2, 5'd3, 32'hA2);
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 3'b000) $display("FAIL rst_ready: got %b expected 000", req_ready); else n_pass++;
      n_checks++;
      if (wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", wr_en); else n_pass++;
      n_checks++;
      if (wr_addr !== '0 || wr_data !== '0)
        $display("FAIL rst_wr_bus: got addr %0d data %h expected 0/0", wr_addr, wr_data);
      else n_pass++;
      n_checks++;
      if (pending !== 32'h0000_000E) $display("FAIL rst_pending: got %h expected 0000000e", pending); else n_pass++;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL rst_first_grant: got %b expected 001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();
  endtask

  task automatic test_round_robin();
    int waits [NR];
    int maxw;
    logic [NR-1:0] exp_r;
    maxw = 0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    set_req(0, 5'd1, 32'hB0); set_req(1, 5'd2, 32'hB1); set_req(2, 5'd3, 32'hB2);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_r = '0;
      exp_r[c % NR] = 1'b1;
      n_checks++;
      if (req_ready !== exp_r) $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, exp_r); else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (wr_en !== 1'b1) $display("FAIL rr_no_bubble c%0d: got %b expected 1", c, wr_en); else n_pass++;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && !req_ready[i]) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > maxw) maxw = waits[i];
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (maxw > NR - 1) $display("FAIL rr_fairness: max wait %0d expected <= %0d", maxw, NR - 1); else n_pass++;
    drain();
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'h0000_90F7);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL single_ready: got %b expected 001", req_ready); else n_pass++;
    n_checks++;
    if (pending[5] !== 1'b1) $display("FAIL single_pend_req: got %b expected 1", pending[5]); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h0000_90F7)
      $display("FAIL single_stage: got en %b addr %0d data %h expected 1/5/000090f7", wr_en, wr_addr, wr_data);
    else n_pass++;
    n_checks++;
    if (pending[5] !== 1'b1) $display("FAIL single_pend_stage: got %b expected 1", pending[5]); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (pending[5] !== 1'b0 || wr_en !== 1'b0)
      $display("FAIL single_retire: got pend %b en %b expected 0/0", pending[5], wr_en);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_drop();
    set_req(1, 5'd0, 32'h0000_FB50);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b010) $display("FAIL zero_ready: got %b expected 010", req_ready); else n_pass++;
    n_checks++;
    if (pending[0] !== 1'b0) $display("FAIL zero_pend_req: got %b expected 0", pending[0]); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0) $display("FAIL zero_dropped: got %b expected 0", wr_en); else n_pass++;
    n_checks++;
    if (pending[0] !== 1'b0) $display("FAIL zero_pend_stage: got %b expected 0", pending[0]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    set_req(2, 5'd9, 32'h99);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b100) $display("FAIL coll_link: got %b expected 100", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    set_req(0, 5'd7, 32'h1111); set_req(1, 5'd7, 32'h2222);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b001 || pending[7] !== 1'b1)
      $display("FAIL coll_first: got ready %b pend %b expected 001/1", req_ready, pending[7]);
    else n_pass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b010 || wr_en !== 1'b1 || wr_data !== 32'h1111 || pending[7] !== 1'b1)
      $display("FAIL coll_second: got ready %b en %b data %h pend %b expected 010/1/00001111/1",
               req_ready, wr_en, wr_data, pending[7]);
    else n_pass++;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h2222 || pending[7] !== 1'b1)
      $display("FAIL coll_last: got en %b addr %0d data %h pend %b expected 1/7/00002222/1",
               wr_en, wr_addr, wr_data, pending[7]);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (pending[7] !== 1'b0) $display("FAIL coll_retire: got %b expected 0", pending[7]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    set_req(0, 5'd12, 32'hDEAD);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL mid_accept: got %b expected 001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    reset_n   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0 || req_ready !== 3'b000 || pending !== '0)
      $display("FAIL mid_in_reset: got en %b ready %b pend %h expected 0/000/0", wr_en, req_ready, pending);
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_req(0, 5'd4, 32'h44); set_req(1, 5'd6, 32'h66);
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL mid_discard: got en %b addr %0d data %h expected 0/0/0", wr_en, wr_addr, wr_data);
    else n_pass++;
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL mid_ptr_reset: got %b expected 001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_drop();
    test_collision();
    test_reset_midstream();
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
